// File: rtl/slave_mem_pkg.sv
// Shared types and constants for the slave_mem memory responder.
package slave_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACK_WAIT,
    RESP_WAIT
  } state_e;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // Wide enough for the largest delay (15) plus the largest jitter (3).
  localparam int DLY_W = 5;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), reloaded with the seed on rst.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic        fb;

  assign fb = q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) q_q <= seed;
    else     q_q <= {q_q[14:0], fb};
  end

  assign q = q_q;

endmodule

// File: rtl/slave_mem.sv
// Memory-backed crossbar slave: pulsed read/write request, delayed ack, delayed read resp.
// Optional delay jitter from an LFSR is enabled with `define SLAVE_MEM_JITTER_EN.
module slave_mem
  import slave_mem_pkg::*;
#(
  parameter int          ADDR_W     = 30,
  parameter int          MEM_WORDS  = 1024,
  parameter int          ACK_DELAY  = 2,
  parameter int          RESP_DELAY = 3,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              cmd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ack,
  output logic              resp,
  output logic [31:0]       rdata
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [DLY_W-1:0]   d_ack, d_resp;
  logic               cmd_q, cmd_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        hold_q;
  logic               ack_fire, resp_fire;
  logic [31:0]        mem [MEM_WORDS];

  // Upper address bits alias onto the low word index by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

`ifdef SLAVE_MEM_JITTER_EN
  logic [15:0] lfsr;
  logic        unused_lfsr_hi;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:4];
  assign d_ack          = DLY_W'(ACK_DELAY) + DLY_W'(lfsr[1:0]);
  assign d_resp         = DLY_W'(RESP_DELAY) + DLY_W'(lfsr[3:2]);
`else
  logic [15:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign d_ack       = DLY_W'(ACK_DELAY);
  assign d_resp      = DLY_W'(RESP_DELAY);
`endif

  // Counter holds cycles remaining before the strobe; zero means "fire this cycle".
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    ack_fire  = 1'b0;
    resp_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          cmd_d   = cmd;
          idx_d   = addr[IDX_W-1:0];
          wdata_d = wdata;
          cnt_d   = d_ack - DLY_W'(1);
          state_d = ACK_WAIT;
        end
      end
      ACK_WAIT: begin
        if (cnt_q == '0) begin
          ack_fire = 1'b1;
          if (cmd_q == CMD_WRITE) begin
            state_d = IDLE;
          end else begin
            cnt_d   = d_resp - DLY_W'(1);
            state_d = RESP_WAIT;
          end
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      RESP_WAIT: begin
        if (cnt_q == '0) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - DLY_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_READ;
      idx_q   <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (ack_fire && cmd_q == CMD_READ) hold_q <= mem[idx_q];
    end
  end

  // NOTE: the array itself is never reset; contents survive rst so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && ack_fire && cmd_q == CMD_WRITE) mem[idx_q] <= wdata_q;
  end

  // A reset landing on a strobe cycle aborts the transaction, so strobes are masked too.
  assign ack   = ack_fire & ~rst;
  assign resp  = resp_fire & ~rst;
  assign rdata = hold_q;

endmodule

// File: tb/tb_slave_mem.sv
// Self-checking bench for slave_mem: vector table, corner sequences, random traffic vs. a word-array model.
module tb_slave_mem;
  import slave_mem_pkg::*;

  localparam int ADDR_W     = 30;
  localparam int MEM_WORDS  = 1024;
  localparam int IDX_W      = $clog2(MEM_WORDS);
  localparam int ACK_DELAY  = 2;
  localparam int RESP_DELAY = 3;
`ifdef SLAVE_MEM_JITTER_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  typedef struct {
    logic              cmd;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              cmd;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              resp;
  logic [31:0]       rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [MEM_WORDS];

  always #5 clk = ~clk;

  slave_mem #(
    .ADDR_W     (ADDR_W),
    .MEM_WORDS  (MEM_WORDS),
    .ACK_DELAY  (ACK_DELAY),
    .RESP_DELAY (RESP_DELAY),
    .LFSR_SEED  (16'hACE1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .cmd   (cmd),
    .addr  (addr),
    .wdata (wdata),
    .ack   (ack),
    .resp  (resp),
    .rdata (rdata)
  );

  // Advance to the next cycle; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, v, lo, hi);
    end
  endtask

  // One full transaction, issued in the cycle after the call; checks latency and strobe exclusivity.
  task automatic do_txn(input logic c, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input string tag, output logic [31:0] rd);
    int d;
    bit got;
    bit clash;
    tick();
    req = 1'b1; cmd = c; addr = a; wdata = wd;
    d = 0; got = 1'b0; clash = 1'b0; rd = '0;
    while (!got && d < 40) begin
      tick();
      req = 1'b0;
      d++;
      if (resp) clash = 1'b1;
      if (ack)  got = 1'b1;
    end
    check_rng({tag, " ack delay"}, got ? d : -1, ACK_DELAY, ACK_DELAY + JIT);
    if (c == CMD_WRITE) model[a[IDX_W-1:0]] = wd;
    if (got && c == CMD_READ) begin
      d = 0; got = 1'b0;
      while (!got && d < 40) begin
        tick();
        d++;
        if (ack) clash = 1'b1;
        if (resp) begin
          got = 1'b1;
          rd  = rdata;
        end
      end
      check_rng({tag, " resp delay"}, got ? d : -1, RESP_DELAY, RESP_DELAY + JIT);
    end
    check({tag, " strobe overlap"}, 32'(clash), 32'd0);
  endtask

  initial begin
    vec_t        vecs [8];
    logic [31:0] rd;
    logic [31:0] exp;
    int          n;
    bit          got;
    bit          seen;

    vecs[0] = '{CMD_WRITE, 30'd5,          32'hDEADBEEF, 32'h0};
    vecs[1] = '{CMD_READ,  30'd5,          32'h0,        32'hDEADBEEF};
    vecs[2] = '{CMD_WRITE, 30'd1024,       32'h00001234, 32'h0};
    vecs[3] = '{CMD_READ,  30'd0,          32'h0,        32'h00001234};
    vecs[4] = '{CMD_WRITE, 30'd1023,       32'hA5A5A5A5, 32'h0};
    vecs[5] = '{CMD_WRITE, 30'h3FFFFFFF,   32'h5555AAAA, 32'h0};
    vecs[6] = '{CMD_READ,  30'd1023,       32'h0,        32'h5555AAAA};
    vecs[7] = '{CMD_READ,  30'd5,          32'h0,        32'hDEADBEEF};

    // Reset: three cycles asserted, then quiet outputs with no requests.
    rst = 1'b1; req = 1'b0; cmd = CMD_READ; addr = '0; wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset ack", 32'(ack), 32'd0);
    check("reset resp", 32'(resp), 32'd0);
    check("reset rdata", rdata, 32'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack || resp) n++;
    end
    check("idle strobes", 32'(n), 32'd0);

    // Directed vectors, including aliasing of upper address bits.
    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].cmd, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), rd);
      if (vecs[i].cmd == CMD_READ) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end
    tick();
    check("rdata held after resp", rdata, 32'hDEADBEEF);

    // Busy ignore: a second request during ACK_WAIT yields no extra ack and no write.
    do_txn(CMD_WRITE, 30'd8, 32'h00008888, "busy pre", rd);
    tick();
    req = 1'b1; cmd = CMD_WRITE; addr = 30'd7; wdata = 32'h00001111;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) begin
        req = 1'b1; cmd = CMD_WRITE; addr = 30'd8; wdata = 32'h00002222;
      end else begin
        req = 1'b0;
      end
      if (ack) n++;
    end
    check("busy ack count", 32'(n), 32'd1);
    model[7] = 32'h00001111;
    do_txn(CMD_READ, 30'd7, '0, "busy rd7", rd);
    check("busy rd7 rdata", rd, 32'h00001111);
    do_txn(CMD_READ, 30'd8, '0, "busy rd8", rd);
    check("busy rd8 rdata", rd, 32'h00008888);

    // Reset mid-read: rst in RESP_WAIT suppresses resp; the next read is normal.
    tick();
    req = 1'b1; cmd = CMD_READ; addr = 30'd5;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      req = 1'b0;
      n++;
      if (ack) got = 1'b1;
    end
    check_rng("rstmid ack delay", got ? n : -1, ACK_DELAY, ACK_DELAY + JIT);
    tick();
    rst  = 1'b1;
    seen = resp;
    tick();
    seen |= resp;
    tick();
    seen |= resp;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= resp;
    end
    check("rstmid no resp", 32'(seen), 32'd0);
    check("rstmid rdata cleared", rdata, 32'd0);
    do_txn(CMD_READ, 30'd5, '0, "rstmid reread", rd);
    check("rstmid reread rdata", rd, 32'hDEADBEEF);

    // Random traffic over a small, fully initialised word set with random upper address bits.
    for (int i = 0; i < 16; i++) begin
      do_txn(CMD_WRITE, ADDR_W'(i), $urandom(), $sformatf("init%0d", i), rd);
    end
    for (int i = 0; i < 100; i++) begin
      logic              c;
      logic [ADDR_W-1:0] a;
      int                w;
      c = 1'($urandom_range(0, 1));
      w = int'($urandom_range(0, 15));
      a = ADDR_W'($urandom());
      a[IDX_W-1:0] = IDX_W'(w);
      exp = model[w];
      do_txn(c, a, $urandom(), $sformatf("rnd%0d", i), rd);
      if (c == CMD_READ) check($sformatf("rnd%0d rdata", i), rd, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
